// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared encodings for the writeback stage. It holds the load length
//            codes, the writeback source select and the FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package wb_pkg;

    // number_length[1:0] access size codes
    localparam logic [1:0] LEN_B = 2'b00;
    localparam logic [1:0] LEN_H = 2'b01;
    localparam logic [1:0] LEN_W = 2'b10;
    localparam logic [1:0] LEN_D = 2'b11;

    // number_length[LEN_UNSIGNED_BIT] = 1 selects zero extension
    localparam int LEN_UNSIGNED_BIT = 2;

    // writeback_src select
    localparam logic WB_SRC_EX  = 1'b0;
    localparam logic WB_SRC_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COMMIT   = 2'd1,
        WAIT_MEM = 2'd2
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/load_align.sv
`default_nettype none
// ============================================================================
// Module   : load_align
// Purpose  : Combinational load data aligner. It selects the byte, half, word
//            or dword field from a raw memory word at an offset aligned to the
//            access size, then sign-extends or zero-extends it to DATA_W.
// Ports    : mem_rdata     in  DATA_W  raw load data word
//            addr_lo       in  OFF_W   byte offset inside the word
//            number_length in  3       [1:0] size, [2] 1 = unsigned
//            load_data     out DATA_W  aligned, extended value
// Revision : 1.0 - initial release
// ============================================================================
module load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [OFF_W-1:0]  addr_lo,
    input  logic [2:0]        number_length,
    output logic [DATA_W-1:0] load_data
);

    logic [OFF_W-1:0]  w_off;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_mask;
    logic              w_sign;
    logic              w_unsigned;

    assign w_unsigned = number_length[LEN_UNSIGNED_BIT];

    // Low offset bits are dropped to size alignment. A misaligned access is
    // trapped upstream, so masking is enough here.
    always_comb begin
        w_off = addr_lo;
        case (number_length[1:0])
            LEN_B:   w_off = addr_lo;
            LEN_H:   w_off = addr_lo & ~OFF_W'(1);
            LEN_W:   w_off = addr_lo & ~OFF_W'(3);
            default: w_off = '0;
        endcase
    end

    assign w_shifted = mem_rdata >> {w_off, 3'b000};

    // w_mask covers the field width. Bits outside the mask receive the sign
    // when the access is signed. A field that fills DATA_W has an all-ones
    // mask, so the sign bit has no effect. This covers word at 32 bits and
    // dword at 64 bits. At DATA_W=32 the dword code also lands on the
    // full-width case: offset 0 and an all-ones mask, the same as a word access.
    always_comb begin
        w_mask = '1;
        w_sign = 1'b0;
        case (number_length[1:0])
            LEN_B: begin
                w_mask = DATA_W'(8'hFF);
                w_sign = ~w_unsigned & w_shifted[7];
            end
            LEN_H: begin
                w_mask = DATA_W'(16'hFFFF);
                w_sign = ~w_unsigned & w_shifted[15];
            end
            LEN_W: begin
                w_mask = DATA_W'(32'hFFFF_FFFF);
                w_sign = ~w_unsigned & w_shifted[31];
            end
            default: begin
                w_mask = '1;
                w_sign = 1'b0;
            end
        endcase
    end

    assign load_data = (w_shifted & w_mask) | (w_sign ? ~w_mask : '0);

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : writeback_stage
// Purpose  : Handshaked writeback stage. It retires one instruction per cycle
//            from MEM and selects the EX result or aligned load data. It waits
//            for late load data, drives the register-file write port, gives
//            decode a busy/forward view of a pending load and counts retired
//            instructions.
// Ports    : clk, rst_n (async, active low), clear (sync flush)
//            in_valid/in_ready handshake; in_ex_result, in_rd_index,
//            in_number_length, in_writeback_valid, in_writeback_src, in_addr_lo
//            mem_rvalid, mem_rdata   late load data return
//            rf_we, rf_waddr, rf_wdata   register-file write port (registered)
//            fwd_busy, fwd_index         pending-load view (registered)
//            retire_cnt                  committed instruction count
// Revision : 1.0 - initial release
// ============================================================================
module writeback_stage
    import wb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32,
    parameter int OFF_W     = $clog2(DATA_W/8)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_ex_result,
    input  logic [REG_IDX_W-1:0] in_rd_index,
    input  logic [2:0]           in_number_length,
    input  logic                 in_writeback_valid,
    input  logic                 in_writeback_src,
    input  logic [OFF_W-1:0]     in_addr_lo,
    input  logic                 mem_rvalid,
    input  logic [DATA_W-1:0]    mem_rdata,
    output logic                 rf_we,
    output logic [REG_IDX_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]    rf_wdata,
    output logic                 fwd_busy,
    output logic [REG_IDX_W-1:0] fwd_index,
    output logic [CNT_W-1:0]     retire_cnt
);

    wb_state_t             r_state;
    wb_state_t             w_state_nxt;

    // Load context latched at acceptance and used when the data returns
    logic [REG_IDX_W-1:0]  r_rd;
    logic [2:0]            r_len;
    logic [OFF_W-1:0]      r_off;

    logic                  w_commit;
    logic                  w_latch;
    logic                  w_we_nxt;
    logic [REG_IDX_W-1:0]  w_waddr_nxt;
    logic [DATA_W-1:0]     w_wdata_nxt;
    logic [DATA_W-1:0]     w_load_val;
    logic [REG_IDX_W-1:0]  w_fwd_rd;

    load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .mem_rdata     (mem_rdata),
        .addr_lo       (r_off),
        .number_length (r_len),
        .load_data     (w_load_val)
    );

    assign in_ready = (r_state != WAIT_MEM);

    // Next-state and commit data. clear overrides everything: a pending load
    // is dropped, and the in_valid of the clear cycle is not accepted.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_latch     = 1'b0;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = '0;
        w_wdata_nxt = '0;
        if (clear) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, COMMIT: begin
                    if (in_valid) begin
                        if (in_writeback_valid && (in_writeback_src == WB_SRC_MEM)) begin
                            // An mem_rvalid in this cycle belongs to an older request
                            w_state_nxt = WAIT_MEM;
                            w_latch     = 1'b1;
                        end else begin
                            w_state_nxt = COMMIT;
                            w_commit    = 1'b1;
                            w_we_nxt    = in_writeback_valid && (in_rd_index != '0);
                            w_waddr_nxt = in_rd_index;
                            w_wdata_nxt = in_ex_result;
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (mem_rvalid) begin
                        w_state_nxt = COMMIT;
                        w_commit    = 1'b1;
                        w_we_nxt    = (r_rd != '0);
                        w_waddr_nxt = r_rd;
                        w_wdata_nxt = w_load_val;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_fwd_rd = w_latch ? in_rd_index : r_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we      <= 1'b0;
            rf_waddr   <= '0;
            rf_wdata   <= '0;
            fwd_busy   <= 1'b0;
            fwd_index  <= '0;
            retire_cnt <= '0;
            r_rd       <= '0;
            r_len      <= '0;
            r_off      <= '0;
        end else begin
            rf_we <= w_we_nxt;
            if (w_commit) begin
                rf_waddr <= w_waddr_nxt;
                rf_wdata <= w_wdata_nxt;
            end
            // Forward view tracks the state being entered, so it is
            // valid in the same cycle the stage sits in WAIT_MEM
            fwd_busy  <= (w_state_nxt == WAIT_MEM) && (w_fwd_rd != '0);
            fwd_index <= (w_state_nxt == WAIT_MEM) ? w_fwd_rd : '0;
            // Every COMMIT cycle retires, even under clear or a suppressed write
            if (r_state == COMMIT) begin
                retire_cnt <= retire_cnt + CNT_W'(1);
            end
            if (w_latch) begin
                r_rd  <= in_rd_index;
                r_len <= in_number_length;
                r_off <= in_addr_lo;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_stage
// Purpose  : Self-checking bench for writeback_stage (DATA_W=32) plus a
//            64-bit load_align instance for the dword path. It runs directed
//            scenarios, then random traffic against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam int CW = 32;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_ex_result = '0;
    logic [RW-1:0] in_rd_index = '0;
    logic [2:0]    in_number_length = '0;
    logic          in_writeback_valid = 1'b0;
    logic          in_writeback_src = 1'b0;
    logic [OW-1:0] in_addr_lo = '0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          rf_we;
    logic [RW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          fwd_busy;
    logic [RW-1:0] fwd_index;
    logic [CW-1:0] retire_cnt;

    always #5 clk = ~clk;

    writeback_stage #(
        .DATA_W    (DW),
        .REG_IDX_W (RW),
        .CNT_W     (CW)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .clear              (clear),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_ex_result       (in_ex_result),
        .in_rd_index        (in_rd_index),
        .in_number_length   (in_number_length),
        .in_writeback_valid (in_writeback_valid),
        .in_writeback_src   (in_writeback_src),
        .in_addr_lo         (in_addr_lo),
        .mem_rvalid         (mem_rvalid),
        .mem_rdata          (mem_rdata),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .fwd_busy           (fwd_busy),
        .fwd_index          (fwd_index),
        .retire_cnt         (retire_cnt)
    );

    logic [63:0] la_data = '0;
    logic [2:0]  la_off = '0;
    logic [2:0]  la_len = '0;
    logic [63:0] la_out;

    load_align #(.DATA_W(64), .OFF_W(3)) u_la64 (
        .mem_rdata     (la_data),
        .addr_lo       (la_off),
        .number_length (la_len),
        .load_data     (la_out)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state (transaction level)
    bit          m_pend;
    int          m_rd;
    logic [2:0]  m_len;
    int          m_off;
    bit          m_commit;
    bit          m_we;
    logic [63:0] m_waddr;
    logic [63:0] m_wdata;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load result from the arithmetic rules: size in bytes, aligned offset,
    // field extraction, then extension
    function automatic logic [63:0] ref_load(input logic [63:0] data, input int off,
                                             input logic [2:0] len, input int width);
        int nbytes;
        int nbits;
        int aoff;
        logic [63:0] field;
        logic [63:0] mask;
        nbytes = 1 << len[1:0];
        if (nbytes * 8 > width) nbytes = width / 8;
        aoff  = off - (off % nbytes);
        nbits = nbytes * 8;
        if (nbits >= width) return (width == 64) ? data : {32'b0, data[31:0]};
        mask  = (64'd1 << nbits) - 64'd1;
        field = (data >> (8 * aoff)) & mask;
        if (!len[2] && field[nbits-1]) field = field | ~mask;
        if (width == 32) field = field & 64'h0000_0000_FFFF_FFFF;
        return field;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_rd = 0; m_len = '0; m_off = 0;
        m_commit = 0; m_we = 0; m_waddr = '0; m_wdata = '0; m_cnt = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rf_we"}, 64'(rf_we), 64'(m_we));
        if (m_commit) begin
            chk({tag, ".rf_waddr"}, 64'(rf_waddr), m_waddr);
            chk({tag, ".rf_wdata"}, 64'(rf_wdata), m_wdata);
        end
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_pend));
        chk({tag, ".fwd_busy"}, 64'(fwd_busy), 64'(m_pend && m_rd != 0));
        chk({tag, ".fwd_index"}, 64'(fwd_index), m_pend ? 64'(m_rd) : 64'd0);
        chk({tag, ".retire_cnt"}, 64'(retire_cnt), 64'(m_cnt));
    endtask

    // Predict from the current inputs, advance one clock, then compare
    task automatic cycle(input string tag);
        bit nc;
        nc = 0;
        if (clear) begin
            m_pend = 0;
        end else if (m_pend) begin
            if (mem_rvalid) begin
                nc = 1;
                m_we = (m_rd != 0);
                m_waddr = 64'(m_rd);
                m_wdata = ref_load(64'(mem_rdata), m_off, m_len, DW);
                m_pend = 0;
            end
        end else if (in_valid) begin
            if (in_writeback_valid && in_writeback_src) begin
                m_pend = 1;
                m_rd = int'(in_rd_index);
                m_len = in_number_length;
                m_off = int'(in_addr_lo);
            end else begin
                nc = 1;
                m_we = in_writeback_valid && (in_rd_index != 0);
                m_waddr = 64'(in_rd_index);
                m_wdata = 64'(in_ex_result);
            end
        end
        if (!nc) m_we = 0;
        if (m_commit) m_cnt = m_cnt + 32'd1;
        m_commit = nc;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic drive(input bit v, input bit wbv, input bit src, input int rd,
                         input logic [31:0] ex, input logic [2:0] len, input int off);
        in_valid = v;
        in_writeback_valid = wbv;
        in_writeback_src = src;
        in_rd_index = RW'(rd);
        in_ex_result = ex;
        in_number_length = len;
        in_addr_lo = OW'(off);
    endtask

    initial begin
        model_reset();
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset.rf_we", 64'(rf_we), 64'd0);
        chk("reset.rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset.in_ready", 64'(in_ready), 64'd1);
        chk("reset.retire_cnt", 64'(retire_cnt), 64'd0);
        rst_n = 1'b1;

        // EX back-to-back
        drive(1, 1, 0, 3, 32'h1234, 3'b010, 0);
        cycle("ex0");
        chk("ex0.we", 64'(rf_we), 64'd1);
        chk("ex0.data", 64'(rf_wdata), 64'h1234);
        drive(1, 1, 0, 4, 32'hABCD, 3'b010, 0);
        cycle("ex1");
        chk("ex1.addr", 64'(rf_waddr), 64'd4);
        chk("ex1.data", 64'(rf_wdata), 64'hABCD);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle("ex2");
        chk("ex2.cnt", 64'(retire_cnt), 64'd2);

        // Signed byte load, 3-cycle miss; acceptance-cycle rvalid ignored
        drive(1, 1, 1, 5, 32'hDEAD, 3'b000, 2);
        mem_rvalid = 1; mem_rdata = 32'h7777_7777;
        cycle("lb.acc");
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_rvalid = 0;
        cycle("lb.w1");
        chk("lb.w1.busy", 64'(fwd_busy), 64'd1);
        chk("lb.w1.idx", 64'(fwd_index), 64'd5);
        chk("lb.w1.ready", 64'(in_ready), 64'd0);
        cycle("lb.w2");
        mem_rvalid = 1; mem_rdata = 32'h0080_0000;
        cycle("lb.ret");
        chk("lb.data", 64'(rf_wdata), 64'hFFFF_FF80);
        chk("lb.we", 64'(rf_we), 64'd1);
        mem_rvalid = 0;

        // Unsigned half load
        drive(1, 1, 1, 6, 0, 3'b101, 2);
        cycle("lhu.acc");
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_rvalid = 1; mem_rdata = 32'h8001_0000;
        cycle("lhu.ret");
        chk("lhu.data", 64'(rf_wdata), 64'h0000_8001);
        mem_rvalid = 0;

        // rd=0 never writes but still retires
        drive(1, 1, 0, 0, 32'h55, 3'b010, 0);
        cycle("rd0");
        chk("rd0.we", 64'(rf_we), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle("rd0.cnt");

        // clear while waiting, then late data returns
        drive(1, 1, 1, 7, 0, 3'b010, 0);
        cycle("clr.acc");
        drive(1, 1, 0, 8, 32'h99, 3'b010, 0);
        clear = 1;
        cycle("clr");
        chk("clr.ready", 64'(in_ready), 64'd1);
        chk("clr.busy", 64'(fwd_busy), 64'd0);
        clear = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        mem_rvalid = 1; mem_rdata = 32'h1111_2222;
        cycle("clr.late");
        chk("clr.late.we", 64'(rf_we), 64'd0);
        mem_rvalid = 0;

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(9, 0) < 7, $urandom_range(9, 0) < 8, $urandom_range(1, 0) == 1,
                  ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(31, 1)),
                  $urandom, 3'($urandom), int'($urandom_range(3, 0)));
            mem_rvalid = $urandom_range(9, 0) < 3;
            mem_rdata = $urandom;
            clear = $urandom_range(19, 0) == 0;
            cycle("rnd");
        end
        clear = 0;
        mem_rvalid = 0;

        // Asynchronous reset in the middle of WAIT_MEM
        drive(1, 1, 1, 9, 0, 3'b010, 0);
        cycle("ar.acc");
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("ar.we", 64'(rf_we), 64'd0);
        chk("ar.busy", 64'(fwd_busy), 64'd0);
        chk("ar.idx", 64'(fwd_index), 64'd0);
        chk("ar.cnt", 64'(retire_cnt), 64'd0);
        chk("ar.ready", 64'(in_ready), 64'd1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
        cycle("ar.post");
        mem_rvalid = 0;
        drive(1, 1, 0, 12, 32'hCAFE, 3'b010, 0);
        cycle("ar.ex");

        // 64-bit aligner: dword passthrough plus random fields
        la_data = 64'h8123_4567_89AB_CDEF; la_off = 0; la_len = 3'b011;
        #1;
        chk("la64.dword", la_out, 64'h8123_4567_89AB_CDEF);
        for (int i = 0; i < 40; i++) begin
            la_data = {$urandom, $urandom};
            la_off = 3'($urandom);
            la_len = 3'($urandom);
            #1;
            chk("la64.rnd", la_out, ref_load(la_data, int'(la_off), la_len, 64));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Parametrised, handshaked successor to the single-register writeback stage.
- Accepts one retiring instruction per cycle from MEM and selects the EX result or load data.
- Aligns and sign/zero-extends load data by access size, waits for late (cache-miss) load data, and drives the register-file write port.
- Also provides a forwarding/busy view for the decode-stage hazard logic and a retire counter.

Parameters:
- DATA_W, 32, datapath width; 32 or 64 only.
- REG_IDX_W, 5, register index width.
- CNT_W, 32, retire counter width.
- OFF_W, $clog2(DATA_W/8), width of the load byte offset (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous pipeline flush, active-high.
- in_valid  in  1  MEM stage presents an instruction.
- in_ready  out  1  stage can accept this cycle.
- in_ex_result  in  DATA_W  ALU/EX result.
- in_rd_index  in  REG_IDX_W  destination register.
- in_number_length  in  3  load size and signedness: [1:0] 00=byte, 01=half, 10=word, 11=dword; [2] 1=unsigned.
- in_writeback_valid  in  1  instruction writes a register.
- in_writeback_src  in  1  0=EX result, 1=memory data.
- in_addr_lo  in  OFF_W  load byte offset within the data word.
- mem_rvalid  in  1  load data returned.
- mem_rdata  in  DATA_W  raw load data word.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  REG_IDX_W  write index.
- rf_wdata  out  DATA_W  write data.
- fwd_busy  out  1  a load is pending for fwd_index.
- fwd_index  out  REG_IDX_W  pending load's destination.
- retire_cnt  out  CNT_W  instructions committed.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE.
  - All outputs 0, except in_ready=1.
  - retire_cnt=0.
- States:
  - IDLE: nothing committing.
  - COMMIT: the rf_* outputs hold a completed instruction for exactly one cycle.
  - WAIT_MEM: a load has been accepted; its data has not yet returned.
- in_ready = (state != WAIT_MEM). An instruction is accepted when in_valid && in_ready.
- Accept in IDLE/COMMIT with src=EX, or with in_writeback_valid=0:
  - Next state COMMIT.
  - rf_wdata=in_ex_result, rf_waddr=in_rd_index, all registered.
  - Latency is 1 cycle; back-to-back throughput is 1 per cycle.
- Accept with src=MEM and in_writeback_valid=1:
  - Next state WAIT_MEM; latch rd_index, number_length and addr_lo.
  - mem_rvalid in the acceptance cycle belongs to an older request and is ignored.
- In WAIT_MEM, on mem_rvalid:
  - Next state COMMIT; rf_wdata = aligned/extended mem_rdata.
  - Without mem_rvalid, stay in WAIT_MEM indefinitely.
- COMMIT with no new accept: next state IDLE.
- mem_rvalid outside WAIT_MEM has no effect.
- Commit outputs:
  - rf_we = committed && writeback_valid && rf_waddr != 0. Index 0 never writes.
  - retire_cnt increments by 1 in every COMMIT cycle, whether or not rf_we is set. It wraps at 2^CNT_W and is not affected by clear.
- Load extraction:
  - Offset is aligned to the access size (in_addr_lo low bits masked; misalignment is trapped upstream).
  - Field = mem_rdata[8*offset +: size].
  - Sign-extend to DATA_W when [2]=0, zero-extend when [2]=1.
  - size=word with DATA_W=32 ignores [2].
  - size=dword is legal only for DATA_W=64; with DATA_W=32 it is treated as word.
- Forwarding view:
  - fwd_busy=1 iff state==WAIT_MEM and the latched rd != 0.
  - fwd_index = latched rd, else 0.
- clear:
  - Priority over everything except reset.
  - Next state IDLE; in-flight instruction dropped; no commit in the following cycle; rf_we=0.
  - Any in_valid in the clear cycle is not accepted.
- rf_* and fwd_* are registered outputs; in_ready is combinational from state.

Decomposition:
- wb_pkg holds:
  - length encodings: LEN_B, LEN_H, LEN_W, LEN_D and the unsigned-bit position.
  - WB_SRC_EX and WB_SRC_MEM.
  - state enum: IDLE, COMMIT, WAIT_MEM.
- One combinational sub-module, load_align (DATA_W, OFF_W): takes raw word, offset and length; returns the extended value.

Test Plan:
- EX back-to-back: accept rd=3 0x1234 then rd=4 0xABCD on consecutive cycles -> rf_we with (3,0x1234) then (4,0xABCD) on consecutive cycles; retire_cnt=2.
- Load byte signed, 3-cycle miss:
  - Stimulus: src=MEM, rd=5, len=000, addr_lo=2; mem_rvalid 3 cycles later with mem_rdata=0x0080_0000.
  - Response: in_ready=0 and fwd_busy=1 with fwd_index=5 while waiting; then rf_wdata=0xFFFF_FF80 one cycle after mem_rvalid.
- Load half unsigned, addr_lo=2, mem_rdata=0x8001_0000 -> rf_wdata=0x0000_8001. With DATA_W=64, dword at offset 0 passes the full 64-bit word through unchanged.
- rd=0 EX write with value 0x55 -> rf_we=0; retire_cnt still increments.
- clear asserted while in WAIT_MEM, then mem_rvalid arrives -> no rf_we; in_ready=1 the next cycle; fwd_busy=0.
- Async reset mid-WAIT_MEM (rst_n low between edges) -> outputs 0 immediately; retire_cnt=0; state IDLE after release.
